// File: rtl/pipeline_controller.sv
// Pipeline controller: shared memory-port arbiter (instruction/data), hazard-driven
// pipeline register controls, sticky halt, and saturating stall/flush counters.
module pipeline_controller #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        d_req,
    input  logic        ID_data_hazard,
    input  logic        Branch_Failed,
    input  logic        Jump_Failed,
    input  logic        wb_halt,
    output logic        mem_start,
    output logic        mem_sel_d,
    output logic        i_done,
    output logic        d_done,
    output logic [1:0]  pc_sel,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IFID_flush,
    output logic        IDEX_write,
    output logic        IDEX_flush,
    output logic        EXMEM_write,
    output logic        MEMWB_bubble,
    output logic        halted,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, HALTED} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        discard_q, discard_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        halt_now;
    logic        flush_evt;

    // Port arbiter: launch, occupancy countdown, completion pulses, halt entry.
    // A halt request parks the arbiter only once any in-flight access has completed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        mem_start = 1'b0;
        mem_sel_d = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        halt_now  = halted_q | wb_halt;
        case (state_q)
            IDLE: begin
                if (halt_now) begin
                    state_d = HALTED;
                end else if (d_req) begin
                    mem_start = 1'b1;
                    mem_sel_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = DBUSY;
                end else if (i_req && !Branch_Failed && !Jump_Failed) begin
                    mem_start = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = IBUSY;
                end
            end
            IBUSY: begin
                if (Branch_Failed || Jump_Failed) begin
                    discard_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    i_done    = ~discard_q;
                    discard_d = 1'b0;
                    state_d   = halt_now ? HALTED : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DBUSY: begin
                mem_sel_d = 1'b1;
                if (cnt_q == '0) begin
                    d_done  = 1'b1;
                    state_d = halt_now ? HALTED : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            mem_start = 1'b0;
            i_done    = 1'b0;
            d_done    = 1'b0;
        end
    end

    // Pipeline register controls: first matching rule wins, everything else defaults.
    always_comb begin
        pc_sel       = 2'd0;
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_write   = 1'b1;
        IDEX_flush   = 1'b0;
        EXMEM_write  = 1'b1;
        MEMWB_bubble = 1'b0;
        flush_evt    = 1'b0;
        if (halted_q) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_write = 1'b0;
        end else if (d_req && !d_done) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            MEMWB_bubble = 1'b1;
        end else if (Branch_Failed) begin
            pc_sel     = 2'd2;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (ID_data_hazard) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else if (Jump_Failed) begin
            pc_sel     = 2'd1;
            IFID_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (i_req && !i_done) begin
            PC_write   = 1'b0;
            IFID_flush = 1'b1;
        end
    end

    // Sticky halt flag and saturating performance counters.
    always_comb begin
        halted_d = halted_q | wb_halt;
        stall_d  = stall_q;
        flush_d  = flush_q;
        if (!halted_q && !PC_write && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
        if (flush_evt && (flush_q != '1)) begin
            flush_d = flush_q + 16'd1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            halted_q  <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Testbench for pipeline_controller: directed scenarios, counter saturation and
// random traffic, all checked against a transaction-level reference model.
module tb_pipeline_controller;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic        ID_data_hazard = 1'b0, Branch_Failed = 1'b0, Jump_Failed = 1'b0;
    logic        wb_halt = 1'b0;
    logic        mem_start, mem_sel_d, i_done, d_done;
    logic [1:0]  pc_sel;
    logic        PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush;
    logic        EXMEM_write, MEMWB_bubble, halted;
    logic [15:0] stall_count, flush_count;

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding transaction described by owner and completion cycle
    int cyc = 0;
    bit m_active = 0;
    bit m_side_d = 0;
    int m_done_cyc = 0;
    bit m_killed = 0;
    bit m_halt = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_controller #(.MEM_LATENCY(ML)) dut (
        .clk(clk), .reset(rst), .i_req(i_req), .d_req(d_req),
        .ID_data_hazard(ID_data_hazard), .Branch_Failed(Branch_Failed),
        .Jump_Failed(Jump_Failed), .wb_halt(wb_halt),
        .mem_start(mem_start), .mem_sel_d(mem_sel_d), .i_done(i_done), .d_done(d_done),
        .pc_sel(pc_sel), .PC_write(PC_write), .IFID_write(IFID_write),
        .IFID_flush(IFID_flush), .IDEX_write(IDEX_write), .IDEX_flush(IDEX_flush),
        .EXMEM_write(EXMEM_write), .MEMWB_bubble(MEMWB_bubble), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_in(input bit ir, input bit dr, input bit hz, input bit bf, input bit jf, input bit wh);
        i_req = ir; d_req = dr; ID_data_hazard = hz;
        Branch_Failed = bf; Jump_Failed = jf; wb_halt = wh;
    endtask

    // One clock cycle: evaluate model, compare at negedge, advance model after posedge.
    task automatic cycle_step();
        bit busy, at_end, e_id, e_dd, e_st, fl_ev;
        bit e_pcw, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;
        logic [1:0] e_pc;
        @(negedge clk);
        if (rst) begin
            m_active = 0; m_killed = 0; m_halt = 0; m_stall = 0; m_flush = 0;
        end
        busy   = m_active;
        at_end = busy && (cyc == m_done_cyc);
        e_id   = at_end && !m_side_d && !m_killed;
        e_dd   = at_end && m_side_d;
        e_st   = !rst && !busy && !m_halt && !wb_halt &&
                 (d_req || (i_req && !Branch_Failed && !Jump_Failed));
        e_pc = 2'd0; e_pcw = 1; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0;
        e_exw = 1; e_bub = 0; fl_ev = 0;
        if (m_halt) begin
            e_pcw = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
        end else if (d_req && !e_dd) begin
            e_pcw = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_bub = 1;
        end else if (Branch_Failed) begin
            e_pc = 2'd2; e_iff = 1; e_idf = 1; fl_ev = 1;
        end else if (ID_data_hazard) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end else if (Jump_Failed) begin
            e_pc = 2'd1; e_iff = 1; fl_ev = 1;
        end else if (i_req && !e_id) begin
            e_pcw = 0; e_iff = 1;
        end
        chk("mem_start", mem_start, e_st);
        if (e_st) chk("mem_sel_launch", mem_sel_d, d_req);
        else if (busy) chk("mem_sel_busy", mem_sel_d, m_side_d);
        chk("i_done", i_done, e_id);
        chk("d_done", d_done, e_dd);
        chk("pc_sel", pc_sel, e_pc);
        chk("PC_write", PC_write, e_pcw);
        chk("IFID_write", IFID_write, e_ifw);
        chk("IFID_flush", IFID_flush, e_iff);
        chk("IDEX_write", IDEX_write, e_idw);
        chk("IDEX_flush", IDEX_flush, e_idf);
        chk("EXMEM_write", EXMEM_write, e_exw);
        chk("MEMWB_bubble", MEMWB_bubble, e_bub);
        chk("halted", halted, m_halt);
        chk("stall_count", stall_count, m_stall[15:0]);
        chk("flush_count", flush_count, m_flush[15:0]);
        @(posedge clk);
        #1;
        if (!rst) begin
            if (!m_halt && !e_pcw && m_stall < 65535) m_stall++;
            if (fl_ev && m_flush < 65535) m_flush++;
            if (e_st) begin
                m_active = 1; m_side_d = d_req; m_done_cyc = cyc + ML; m_killed = 0;
            end else if (busy) begin
                if (!m_side_d && (Branch_Failed || Jump_Failed)) m_killed = 1;
                if (at_end) m_active = 0;
            end
            if (wb_halt) m_halt = 1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cycle_step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_halted", halted, 1'b0);
        chk("rst_stall", stall_count, 16'd0);

        // Single fetch: start at cycle 0, i_done at cycle ML, stalled ML cycles
        for (int i = 0; i <= ML; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            cycle_step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        cycle_step();
        chk("fetch_stall_total", stall_count, 16'(ML));

        // Data and fetch together: data wins, fetch follows after d_done
        do_reset();
        for (int i = 0; i <= ML; i++) begin
            set_in(1, 1, 0, 0, 0, 0);
            cycle_step();
        end
        for (int i = 0; i <= ML; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            cycle_step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        cycle_step();

        // Branch redirect in second busy cycle discards the fetch
        do_reset();
        set_in(1, 0, 0, 0, 0, 0); cycle_step();
        set_in(1, 0, 0, 0, 0, 0); cycle_step();
        set_in(1, 0, 0, 1, 0, 0); cycle_step();
        set_in(1, 0, 0, 0, 0, 0); cycle_step();
        set_in(1, 0, 0, 0, 0, 0); cycle_step();
        set_in(0, 0, 0, 0, 0, 0); cycle_step();
        chk("branch_flush_total", flush_count, 16'd1);

        // Data hazard outranks jump redirect
        do_reset();
        set_in(0, 0, 1, 0, 1, 0); cycle_step();
        set_in(0, 0, 0, 0, 0, 0); cycle_step();
        chk("hazard_jump_flush", flush_count, 16'd0);

        // Halt during a data access: access completes, then frozen
        do_reset();
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        set_in(0, 1, 0, 0, 0, 1); cycle_step();
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            cycle_step();
        end
        chk("halt_sticky", halted, 1'b1);
        do_reset();
        chk("halt_cleared", halted, 1'b0);
        chk("halt_cnt_cleared", stall_count, 16'd0);

        // Reset in the middle of a data access aborts it
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        rst = 1'b1;
        set_in(0, 1, 0, 0, 0, 0); cycle_step();
        rst = 1'b0;
        for (int i = 0; i < ML; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            cycle_step();
        end
        chk("abort_counters", stall_count, 16'd0);

        // Stall counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            set_in(0, 0, 1, 0, 0, 0);
            cycle_step();
        end
        chk("stall_saturated", stall_count, 16'hFFFF);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            cycle_step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MEM_LATENCY, default 4, memory-port busy cycles per access (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  IF stage needs an instruction fetch through the shared memory port.
REQ-005 d_req  input  1  MEM stage holds a load/store needing the shared memory port.
REQ-006 ID_data_hazard, Branch_Failed, Jump_Failed  input  1 each  hazard flags from the hazard detector.
REQ-007 wb_halt  input  1  HLT instruction is in the WB stage.
REQ-008 mem_start  output  1  one-cycle pulse that launches a memory access.
REQ-009 mem_sel_d  output  1  port owner for the launched or in-flight access: 1 = data side, 0 = instruction side.
REQ-010 i_done, d_done  output  1 each  one-cycle completion pulses.
REQ-011 pc_sel  output  2  PC source select: 0 = PC+1, 1 = ID jump target, 2 = EX branch target.
REQ-012 PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write, MEMWB_bubble  output  1 each  pipeline register controls.
REQ-013 halted  output  1  sticky halt indication.
REQ-014 stall_count, flush_count  output  16 each  saturating performance counters.

Function
REQ-015 The port arbiter SHALL have four states: IDLE, IBUSY, DBUSY, HALTED, plus a 4-bit down-counter cnt and a discard flag.
REQ-016 In IDLE with d_req=1, the block SHALL assert mem_start with mem_sel_d=1, load cnt=MEM_LATENCY-1, and enter DBUSY.
REQ-017 In IDLE with d_req=0, i_req=1 and no redirect (Branch_Failed=0 and Jump_Failed=0), the block SHALL assert mem_start with mem_sel_d=0, load cnt=MEM_LATENCY-1, and enter IBUSY.
REQ-018 When d_req and i_req are both 1 in IDLE, the data side SHALL win; the fetch starts no earlier than the cycle after d_done.
REQ-019 In IBUSY and DBUSY, cnt SHALL decrement each cycle.
REQ-020 In the BUSY cycle with cnt=0, the block SHALL pulse d_done (DBUSY) or i_done (IBUSY, discard=0) and return to IDLE.
REQ-021 Occupancy SHALL be exactly MEM_LATENCY BUSY cycles per access; no new mem_start SHALL occur while busy.
REQ-022 If Branch_Failed or Jump_Failed is 1 in any IBUSY cycle, discard SHALL be set.
REQ-023 While discard is set, the access SHALL run to completion, i_done SHALL be suppressed, and discard SHALL clear on return to IDLE.
REQ-024 The first applicable rule below SHALL set the pipeline controls; every control not named takes its default: PC_write, IFID_write, IDEX_write, EXMEM_write = 1; flushes, MEMWB_bubble = 0; pc_sel = 0.
REQ-025 Rule (a) halted=1: all writes 0, flushes 0.
REQ-026 Rule (b) d_req=1 and d_done=0: PC_write, IFID_write, IDEX_write, EXMEM_write = 0 and MEMWB_bubble = 1 (full freeze; redirects deferred).
REQ-027 Rule (c) Branch_Failed: pc_sel=2, IFID_flush=1, IDEX_flush=1.
REQ-028 Rule (d) ID_data_hazard: PC_write=0, IFID_write=0, IDEX_flush=1.
REQ-029 Rule (e) Jump_Failed: pc_sel=1, IFID_flush=1.
REQ-030 Rule (f) i_req=1 and i_done=0: PC_write=0, IFID_flush=1.
REQ-031 wb_halt=1 (while not in reset) SHALL set halted and enter HALTED on the next edge.
REQ-032 An in-flight access SHALL complete (done pulse still issued) before HALTED is entered; HALTED SHALL issue no mem_start and SHALL exit only on reset.
REQ-033 stall_count SHALL increment each cycle in which halted=0 and PC_write=0, and SHALL saturate at 16'hFFFF.
REQ-034 flush_count SHALL increment each cycle in which rule (c) or (e) is applied, and SHALL saturate at 16'hFFFF.

Reset
REQ-035 reset=1 SHALL immediately force state IDLE, cnt=0, discard=0, halted=0, and both counters to 0; mem_start, i_done and d_done SHALL be 0 while reset=1.
REQ-036 Reset during IBUSY/DBUSY SHALL abort the access with no done pulse.

Verification
REQ-037 MEM_LATENCY=4, i_req=1 from cycle 0 after reset release -> mem_start cycle 0 with mem_sel_d=0; i_done cycle 4; PC_write=0 cycles 0-3 and 1 at cycle 4; stall_count=4.
REQ-038 i_req=d_req=1 in IDLE, MEM_LATENCY=2 -> d mem_start cycle 0, d_done cycle 2, i mem_start cycle 3 (with i_req still 1), i_done cycle 5.
REQ-039 Branch_Failed=1 in 2nd IBUSY cycle -> pc_sel=2, IFID_flush=IDEX_flush=1 that cycle; no i_done at end of access; flush_count=1.
REQ-040 ID_data_hazard=Jump_Failed=1 same cycle, no memory activity -> PC_write=0, IFID_write=0, IDEX_flush=1, IFID_flush=0, flush_count unchanged.
REQ-041 wb_halt pulse during DBUSY (cnt=2) -> d_done still pulses; then halted=1, all writes 0, no mem_start; reset clears halted and counters.
REQ-042 reset asserted mid-DBUSY -> immediate IDLE; no d_done; counters read 0.
